// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: shared state encoding and constants for the pipeline stall sequencer
package pipe_stall_ctrl_pkg;
  typedef enum logic {RUN, MUL} state_t;
  localparam int MUL_CYCLES_DEF = 4;
  localparam int MUL_CYCLES_MIN = 2;
  localparam int MUL_CYCLES_MAX = 16;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int STALL_CNT_W = 16;
endpackage

// File: rtl/pipe_hazard_cmp.sv
// pipe_hazard_cmp: combinational load-use hazard detect between ID sources and EX load destination
module pipe_hazard_cmp
  import pipe_stall_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_src_a,
  input  logic [4:0] id_src_b,
  input  logic       id_uses_b,
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [4:0] ex_dst,
  output logic       lu
);
  assign lu = id_valid & ex_valid & ex_is_load & (ex_dst != REG_ZERO) &
              ((id_src_a == ex_dst) | (id_uses_b & (id_src_b == ex_dst)));
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: Mealy hazard/stall sequencer driving PC and pipeline register enables
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int CNT_W      = STALL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_src_a,
  input  logic [4:0]       id_src_b,
  input  logic             id_uses_b,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_dst,
  input  logic             ex_branch_taken,
  input  logic             ex_mul_start,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             mul_busy,
  output logic             proto_err,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t     state_q, state_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic       lu, err_set;
  pipe_hazard_cmp u_cmp (
    .id_valid   (id_valid),
    .id_src_a   (id_src_a),
    .id_src_b   (id_src_b),
    .id_uses_b  (id_uses_b),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_dst     (ex_dst),
    .lu         (lu)
  );
  assign mul_busy = (state_q == MUL);
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    state_d      = state_q;
    mcnt_d       = mcnt_q;
    err_set      = 1'b0;
    if (state_q == RUN) begin
      err_set = ex_branch_taken & ex_mul_start;
      if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (ex_mul_start) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_bubble = 1'b1;
        state_d      = MUL;
        mcnt_d       = 4'(MUL_CYCLES - 2);
      end else if (lu) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
    end else begin
      // branch/mul-start are illegal here: flagged, otherwise ignored
      err_set = ex_branch_taken | ex_mul_start;
      if (mcnt_q != 4'd0) begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_bubble = 1'b1;
        mcnt_d       = mcnt_q - 4'd1;
      end else begin
        state_d = RUN;
        if (lu) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
    end
    if (!rst_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      mcnt_q    <= 4'd0;
      proto_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state_q   <= state_d;
      mcnt_q    <= mcnt_d;
      proto_err <= proto_err | err_set;
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: table-driven and directed checks of the stall sequencer
module tb_pipe_stall_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       id_valid, id_uses_b, ex_valid, ex_is_load, ex_branch_taken, ex_mul_start;
  logic [4:0] id_src_a, id_src_b, ex_dst;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, mul_busy, proto_err;
  logic [3:0] stall_cnt;
  logic [5:0] outs;
  int pass_n = 0, tot_n = 0;
  localparam logic [5:0] DEF = 6'b110100, LUO = 6'b000110, BRO = 6'b111110,
                         FRZ = 6'b000001, RSTO = 6'b001011;
  typedef struct {
    logic idv; logic [4:0] sa; logic [4:0] sb; logic ub; logic exv; logic ld;
    logic [4:0] dst; logic br; logic [5:0] exp;
  } vec_t;
  vec_t tbl [10];
  vec_t idle_v, lu_v, br_v;
  int exp_cnt;
  always #5 clk = ~clk;
  assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble};
  pipe_stall_ctrl #(.MUL_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_uses_b(id_uses_b), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dst(ex_dst),
    .ex_branch_taken(ex_branch_taken), .ex_mul_start(ex_mul_start), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble), .mul_busy(mul_busy), .proto_err(proto_err), .stall_cnt(stall_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic drive(input vec_t v, input logic ms);
    @(negedge clk);
    id_valid = v.idv; id_src_a = v.sa; id_src_b = v.sb; id_uses_b = v.ub;
    ex_valid = v.exv; ex_is_load = v.ld; ex_dst = v.dst; ex_branch_taken = v.br;
    ex_mul_start = ms;
    #1;
  endtask
  task automatic chk_rst(input string name);
    chk({name, "_outs"}, 32'(outs), 32'(RSTO));
    chk({name, "_busy"}, 32'(mul_busy), 0);
    chk({name, "_err"}, 32'(proto_err), 0);
    chk({name, "_cnt"}, 32'(stall_cnt), 0);
  endtask
  initial begin
    idle_v = '{0, 0, 0, 0, 0, 0, 0, 0, DEF};
    lu_v   = '{1, 5, 0, 0, 1, 1, 5, 0, LUO};
    br_v   = '{0, 0, 0, 0, 0, 0, 0, 1, BRO};
    tbl[0] = '{1, 5, 0, 0, 1, 1, 5, 0, LUO};
    tbl[1] = '{1, 5, 0, 0, 1, 0, 5, 0, DEF};
    tbl[2] = '{1, 0, 0, 0, 1, 1, 0, 0, DEF};
    tbl[3] = '{1, 1, 5, 0, 1, 1, 5, 0, DEF};
    tbl[4] = '{1, 1, 5, 1, 1, 1, 5, 0, LUO};
    tbl[5] = '{0, 5, 0, 0, 1, 1, 5, 0, DEF};
    tbl[6] = '{1, 5, 0, 0, 0, 1, 5, 0, DEF};
    tbl[7] = '{1, 5, 0, 0, 1, 1, 5, 1, BRO};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 1, BRO};
    tbl[9] = '{1, 6, 0, 0, 1, 1, 5, 0, DEF};
    id_valid = 0; id_src_a = 0; id_src_b = 0; id_uses_b = 0; ex_valid = 0;
    ex_is_load = 0; ex_dst = 0; ex_branch_taken = 0; ex_mul_start = 0;
    #12;
    chk_rst("reset");
    @(negedge clk) rst_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i], 1'b0);
      chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(tbl[i].exp));
      chk($sformatf("vec%0d_cnt", i), 32'(stall_cnt), 32'(exp_cnt));
      if (!tbl[i].exp[5]) exp_cnt++;
    end
    // multi-cycle op: 3 frozen cycles, release in cycle 4 with a load-use honoured
    drive(idle_v, 1'b1);
    chk("mul_c1_outs", 32'(outs), 32'(FRZ));
    chk("mul_c1_busy", 32'(mul_busy), 0);
    for (int c = 2; c <= 3; c++) begin
      drive(idle_v, 1'b0);
      chk($sformatf("mul_c%0d_outs", c), 32'(outs), 32'(FRZ));
      chk($sformatf("mul_c%0d_busy", c), 32'(mul_busy), 1);
    end
    drive(lu_v, 1'b0);
    chk("mul_rel_lu_outs", 32'(outs), 32'(LUO));
    chk("mul_rel_cnt", 32'(stall_cnt), 32'(exp_cnt + 3));
    drive(idle_v, 1'b0);
    chk("mul_after_outs", 32'(outs), 32'(DEF));
    chk("mul_after_busy", 32'(mul_busy), 0);
    chk("mul_after_cnt", 32'(stall_cnt), 32'(exp_cnt + 4));
    chk("mul_after_err", 32'(proto_err), 0);
    // reset in the 2nd MUL cycle
    drive(idle_v, 1'b1);
    drive(idle_v, 1'b0);
    chk("mrst_c2_busy", 32'(mul_busy), 1);
    rst_n = 1'b0;
    #1;
    chk_rst("mrst");
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("mrst_post_outs", 32'(outs), 32'(DEF));
    chk("mrst_post_busy", 32'(mul_busy), 0);
    drive(idle_v, 1'b0);
    chk("mrst_post2_outs", 32'(outs), 32'(DEF));
    // branch during MUL is ignored but latches proto_err
    drive(idle_v, 1'b1);
    drive(br_v, 1'b0);
    chk("perr_br_outs", 32'(outs), 32'(FRZ));
    drive(idle_v, 1'b0);
    chk("perr_set", 32'(proto_err), 1);
    chk("perr_c3_outs", 32'(outs), 32'(FRZ));
    drive(idle_v, 1'b0);
    chk("perr_rel_outs", 32'(outs), 32'(DEF));
    for (int c = 0; c < 3; c++) drive(idle_v, 1'b0);
    chk("perr_sticky", 32'(proto_err), 1);
    chk("perr_run_busy", 32'(mul_busy), 0);
    rst_n = 1'b0;
    #1;
    chk("perr_rst_clr", 32'(proto_err), 0);
    @(negedge clk) rst_n = 1'b1;
    // branch and mul-start together in RUN: branch wins, proto_err set
    drive(br_v, 1'b1);
    chk("brmul_outs", 32'(outs), 32'(BRO));
    drive(idle_v, 1'b0);
    chk("brmul_busy", 32'(mul_busy), 0);
    chk("brmul_err", 32'(proto_err), 1);
    chk("brmul_outs2", 32'(outs), 32'(DEF));
    // held hazard saturates the 4-bit counter
    rst_n = 1'b0;
    #1;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 20; c++) drive(lu_v, 1'b0);
    chk("sat_outs", 32'(outs), 32'(LUO));
    chk("sat_cnt", 32'(stall_cnt), 15);
    drive(lu_v, 1'b0);
    chk("sat_hold", 32'(stall_cnt), 15);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Hazard and stall sequencer for the 5-stage pipeline. Drives the load-enable, flush and bubble controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three conditions:
- load-use data hazards,
- taken branches resolved in EX,
- multi-cycle EX operations such as MUL.

It sits beside the datapath, reads register-specifier and opcode-derived fields from the ID and EX stages, and asserts the controls in the same cycle.

## Interface
Parameters:
- MUL_CYCLES, 4: total EX occupancy of a multi-cycle op, including its first cycle; legal range 2..16.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_src_a  in  5  first source register of the ID instruction.
- id_src_b  in  5  second source register of the ID instruction.
- id_uses_b  in  1  ID instruction reads id_src_b.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_dst  in  5  destination register of the EX instruction.
- ex_branch_taken  in  1  EX instruction is a branch resolved taken.
- ex_mul_start  in  1  first EX cycle of a multi-cycle op; single-cycle pulse.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_en  out  1  ID/EX load enable.
- idex_bubble  out  1  ID/EX loads a NOP.
- exmem_bubble  out  1  EX/MEM loads a NOP.
- mul_busy  out  1  controller is in the MUL state.
- proto_err  out  1  sticky flag for an illegal input combination.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- The state register holds one of two states, RUN and MUL, plus a 4-bit down-counter mcnt.
- All control outputs are combinational from the state and the current inputs (Mealy). The state, mcnt, proto_err and stall_cnt are registered.
- Load-use hazard (lu) = id_valid & ex_valid & ex_is_load & (ex_dst != 0) & (id_src_a == ex_dst | (id_uses_b & id_src_b == ex_dst)).
- Default outputs in RUN: pc_en=1, ifid_en=1, idex_en=1, all flush/bubble outputs=0.
- Priority in RUN, highest first:
  - ex_branch_taken: ifid_flush=1 and idex_bubble=1; pc_en=1 so the redirect loads. Any lu or ex_mul_start in the same cycle is ignored.
  - ex_mul_start: pc_en=0, ifid_en=0, idex_en=0, exmem_bubble=1. Next state is MUL with mcnt = MUL_CYCLES-2.
  - lu: pc_en=0, ifid_en=0, idex_bubble=1, idex_en=1. The state stays RUN. The hazard clears on its own the next cycle as the load advances.
- MUL state:
  - While mcnt != 0: same freeze outputs as the mul-start cycle; mcnt decrements each cycle.
  - At mcnt == 0 (release cycle): RUN default outputs, and lu is evaluated normally. Next state is RUN.
  - ex_branch_taken and ex_mul_start are not expected while in MUL. If either arrives in MUL, it is ignored and proto_err is set.
- ex_branch_taken & ex_mul_start together in RUN also sets proto_err.
- proto_err is cleared only by reset.
- stall_cnt increments in every cycle with rst_n high and pc_en == 0. It saturates at all-ones.

## Timing
- Zero-cycle latency: the controls reflect same-cycle inputs.
- A load-use stall lasts exactly 1 cycle per hazard.
- A multi-cycle op freezes IF, ID and EX for MUL_CYCLES-1 cycles. Release occurs in cycle MUL_CYCLES, counting the start cycle as 1.
- A branch costs 2 flushed slots, IF/ID and ID/EX, in the same cycle.
- While rst_n is low:
  - pc_en, ifid_en and idex_en are 0.
  - ifid_flush, idex_bubble and exmem_bubble are 1.
  - mul_busy=0, proto_err=0, stall_cnt=0.
  - State is RUN and mcnt=0.
- Reset asserted mid-MUL aborts the sequence immediately. After deassertion the block resumes in RUN with no residual stall.

## Structure
- A shared package holds:
  - the state enum {RUN, MUL},
  - the MUL_CYCLES default and legal bounds,
  - the register-zero constant (5'd0),
  - CNT_W.
- One natural sub-module is pipe_hazard_cmp: a purely combinational load-use comparator producing lu. It is reusable by a future forwarding unit.
- The FSM, mcnt, stall_cnt and proto_err stay in the top-level block.

## Test plan
- Load-use on src_a: ex_valid=1, ex_is_load=1, ex_dst=5; id_valid=1, id_src_a=5. Required: 1 cycle with pc_en=0, ifid_en=0, idex_bubble=1. The next cycle returns to defaults and stall_cnt=1.
- Register-zero and unused-operand cases:
  - ex_dst=0 with id_src_a=0: no stall.
  - id_src_b=5, ex_dst=5, id_uses_b=0: no stall.
- Branch versus load-use: ex_branch_taken=1 in the same cycle as an lu condition. Required: ifid_flush=1, idex_bubble=1, pc_en=1, stall_cnt unchanged.
- MUL with MUL_CYCLES=4: pulse ex_mul_start. Required: 3 cycles with pc_en=ifid_en=idex_en=0 and exmem_bubble=1, with mul_busy=1 in cycles 2-3. Cycle 4 is the release. stall_cnt reaches 3.
- Protocol error: reset asserted in the 2nd MUL cycle forces reset values, and state is RUN after deassertion. Separately, ex_branch_taken pulsed during MUL sets proto_err, which stays 1 until reset.
- Counter saturation: with CNT_W=4, hold a lu condition for 20 cycles. Required: stall_cnt saturates at 15.
